// File: rtl/game_period_ctrl.sv
// Game-period controller: timed round on gameSig, symbol shift window, special-symbol count,
// answer handshake. Optional pause input enabled by defining GP_PAUSE_EN.
module game_period_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PERIOD_SEC = 15,
  parameter int unsigned TIME_W     = 8,
  parameter int unsigned CNT_W      = 8,
  parameter logic [7:0]  BLANK_SEG  = 8'hFF
) (
  input  logic                    Clk100M,
  input  logic                    Rst_n,
  input  logic                    tickSec,
  input  logic                    gameSig,
  input  logic                    abortSig,
`ifdef GP_PAUSE_EN
  input  logic                    pauseSig,
`endif
  input  logic [TIME_W-1:0]       periodSec,
  input  logic                    symValid,
  input  logic                    symSpecial,
  input  logic [7:0]              symCode,
  input  logic                    answerAck,
  output logic                    startGen,
  output logic                    stopGen,
  output logic                    answerValid,
  output logic                    busy,
  output logic [TIME_W-1:0]       timeLeft,
  output logic [CNT_W-1:0]        numSpecial,
  output logic [8*NUM_DIGITS-1:0] gameSegs
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t                    r_state, w_state;
  logic                      r_start, w_start;
  logic                      r_stop, w_stop;
  logic                      r_ans, w_ans;
  logic [TIME_W-1:0]         r_time, w_time;
  logic [CNT_W-1:0]          r_num, w_num;
  logic [8*NUM_DIGITS-1:0]   r_segs, w_segs;
  logic [8*NUM_DIGITS-1:0]   w_shift;
  logic                      w_go;
  logic                      w_pause;

`ifdef GP_PAUSE_EN
  assign w_pause = pauseSig;
`else
  assign w_pause = 1'b0;
`endif

  always_comb begin
    w_shift = r_segs;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_shift[8*k +: 8] = r_segs[8*(k-1) +: 8];
    end
    w_shift[7:0] = symCode;
  end

  always_comb begin
    w_state = r_state;
    w_start = 1'b0;
    w_stop  = 1'b0;
    w_ans   = r_ans;
    w_time  = r_time;
    w_num   = r_num;
    w_segs  = r_segs;
    w_go    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (gameSig) w_go = 1'b1;
      end
      S_START: begin
        w_state = S_RUN;
      end
      S_RUN: begin
        if (gameSig) begin
          w_go = 1'b1;
        end else if (abortSig) begin
          w_stop  = 1'b1;
          w_state = S_IDLE;
        end else if (!w_pause) begin
          // Tick and symbol are independent: a symbol on the final tick is still accepted.
          if (tickSec) begin
            if (r_time == TIME_W'(1)) begin
              w_time  = '0;
              w_stop  = 1'b1;
              w_ans   = 1'b1;
              w_state = S_DONE;
            end else if (r_time != '0) begin
              w_time = r_time - TIME_W'(1);
            end
          end
          if (symValid) begin
            w_segs = w_shift;
            if (symSpecial && (r_num != '1)) w_num = r_num + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (gameSig) begin
          w_go = 1'b1;
        end else if (answerAck) begin
          w_ans   = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // Start actions are registered on entry to START so outputs appear one edge after gameSig.
    if (w_go) begin
      w_state = S_START;
      w_start = 1'b1;
      w_ans   = 1'b0;
      w_time  = (periodSec != '0) ? periodSec : TIME_W'(PERIOD_SEC);
      w_num   = '0;
      w_segs  = {NUM_DIGITS{BLANK_SEG}};
    end
  end

  always_ff @(posedge Clk100M) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_ans   <= 1'b0;
      r_time  <= '0;
      r_num   <= '0;
      r_segs  <= {NUM_DIGITS{BLANK_SEG}};
    end else begin
      r_state <= w_state;
      r_start <= w_start;
      r_stop  <= w_stop;
      r_ans   <= w_ans;
      r_time  <= w_time;
      r_num   <= w_num;
      r_segs  <= w_segs;
    end
  end

  assign startGen    = r_start;
  assign stopGen     = r_stop;
  assign answerValid = r_ans;
  assign busy        = (r_state != S_IDLE);
  assign timeLeft    = r_time;
  assign numSpecial  = r_num;
  assign gameSegs    = r_segs;

endmodule

// File: tb/tb_game_period_ctrl.sv
// Scoreboard bench for game_period_ctrl: expected start/stop/answer events are queued by the
// stimulus and checked by a negedge monitor; a CNT_W=2 instance checks count saturation.
module tb_game_period_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, tick, game, abrt, pause, sv, ss, ack;
  logic [7:0]  period, code;
  logic        st, sp, av, bz;
  logic [7:0]  tl, ns;
  logic [31:0] segs;
  logic        st2, sp2, av2, bz2;
  logic [7:0]  tl2;
  logic [1:0]  ns2;
  logic [31:0] segs2;

  always #5 clk = ~clk;

  game_period_ctrl dut (
    .Clk100M(clk), .Rst_n(rst_n), .tickSec(tick), .gameSig(game), .abortSig(abrt),
`ifdef GP_PAUSE_EN
    .pauseSig(pause),
`endif
    .periodSec(period), .symValid(sv), .symSpecial(ss), .symCode(code), .answerAck(ack),
    .startGen(st), .stopGen(sp), .answerValid(av), .busy(bz), .timeLeft(tl),
    .numSpecial(ns), .gameSegs(segs)
  );

  game_period_ctrl #(.CNT_W(2)) dut2 (
    .Clk100M(clk), .Rst_n(rst_n), .tickSec(tick), .gameSig(game), .abortSig(abrt),
`ifdef GP_PAUSE_EN
    .pauseSig(pause),
`endif
    .periodSec(period), .symValid(sv), .symSpecial(ss), .symCode(code), .answerAck(ack),
    .startGen(st2), .stopGen(sp2), .answerValid(av2), .busy(bz2), .timeLeft(tl2),
    .numSpecial(ns2), .gameSegs(segs2)
  );

  typedef struct {
    int          kind;   // 0 startGen, 1 stopGen, 2 answerValid rise
    logic [7:0]  tl;
    logic [7:0]  ns;
    logic [31:0] segs;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic prev_av = 1'b0;

  task automatic push(input int kind, input logic [7:0] t, input logic [7:0] n, input logic [31:0] s);
    ev_t e;
    e.kind = kind; e.tl = t; e.ns = n; e.segs = s;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL event: unexpected kind=%0d (tl=%0d ns=%0d segs=%h), none expected", kind, tl, ns, segs);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.tl != tl || e.ns != ns || e.segs != segs) begin
        n_fail++;
        $display("FAIL event: got kind=%0d tl=%0d ns=%0d segs=%h, expected kind=%0d tl=%0d ns=%0d segs=%h",
                 kind, tl, ns, segs, e.kind, e.tl, e.ns, e.segs);
      end
    end
  endtask

  always @(negedge clk) begin
    if (st) pop_cmp(0);
    if (sp) pop_cmp(1);
    if (av && !prev_av) pop_cmp(2);
    prev_av = av;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [7:0] p, input logic [7:0] exp_tl);
    period = p;
    push(0, exp_tl, 8'd0, 32'hFFFFFFFF);
    game = 1'b1; cyc();
    game = 1'b0; cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes [5];
    logic       spec  [5];
    codes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    spec  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; tick = 0; game = 0; abrt = 0; pause = 0; sv = 0; ss = 0; ack = 0;
    period = 8'd0; code = 8'd0;
    cyc(3);
    chk("reset_busy", {31'd0, bz}, 32'd0);
    chk("reset_av", {31'd0, av}, 32'd0);
    chk("reset_tl", {24'd0, tl}, 32'd0);
    chk("reset_ns", {24'd0, ns}, 32'd0);
    chk("reset_segs", segs, 32'hFFFFFFFF);
    rst_n = 1'b1; cyc();

    // T1: default period, full countdown
    start_round(8'd0, 8'd15);
    chk("t1_tl_start", {24'd0, tl}, 32'd15);
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        push(1, 8'd0, 8'd0, 32'hFFFFFFFF);
        push(2, 8'd0, 8'd0, 32'hFFFFFFFF);
      end
      tick = 1'b1; cyc();
      tick = 1'b0;
      chk("t1_tl", {24'd0, tl}, 32'(15 - i));
      cyc();
    end
    cyc(3);
    chk("t1_av_held", {31'd0, av}, 32'd1);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("t1_av_clr", {31'd0, av}, 32'd0);
    chk("t1_idle", {31'd0, bz}, 32'd0);

    // T2: window shift and special count
    start_round(8'd3, 8'd3);
    for (int i = 0; i < 5; i++) begin
      sv = 1'b1; code = codes[i]; ss = spec[i]; cyc();
    end
    sv = 1'b0; ss = 1'b0; cyc();
    chk("t2_segs", segs, 32'h02030405);
    chk("t2_ns", {24'd0, ns}, 32'd2);
    chk("t2_ns_w2", {30'd0, ns2}, 32'd2);
    chk("t2_tl", {24'd0, tl}, 32'd3);

    // T3: saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      sv = 1'b1; ss = 1'b1; code = 8'h10 + 8'(i); cyc();
    end
    sv = 1'b0; ss = 1'b0; cyc();
    chk("t3_ns_sat", {30'd0, ns2}, 32'd3);
    chk("t3_ns_wide", {24'd0, ns}, 32'd7);
    chk("t3_segs", segs, 32'h11121314);

    // T4a: abort keeps digits and count, no answer
    push(1, 8'd3, 8'd7, 32'h11121314);
    abrt = 1'b1; cyc(); abrt = 1'b0; cyc(3);
    chk("t4_abort_idle", {31'd0, bz}, 32'd0);
    chk("t4_abort_av", {31'd0, av}, 32'd0);
    chk("t4_abort_segs", segs, 32'h11121314);
    chk("t4_abort_ns", {24'd0, ns}, 32'd7);

    // T5a: symbol on the final tick is accepted
    start_round(8'd2, 8'd2);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t5_tl1", {24'd0, tl}, 32'd1);
    push(1, 8'd0, 8'd1, 32'hFFFFFFAB);
    push(2, 8'd0, 8'd1, 32'hFFFFFFAB);
    tick = 1'b1; sv = 1'b1; ss = 1'b1; code = 8'hAB; cyc();
    tick = 1'b0; sv = 1'b0; ss = 1'b0;
    chk("t5_final_segs", segs, 32'hFFFFFFAB);
    chk("t5_final_ns", {24'd0, ns}, 32'd1);
    sv = 1'b1; tick = 1'b1; code = 8'h77; cyc(); sv = 1'b0; tick = 1'b0;
    chk("done_sym_ignored", segs, 32'hFFFFFFAB);
    chk("done_tl_hold", {24'd0, tl}, 32'd0);

    // T4b: gameSig wins over answerAck in DONE
    period = 8'd0;
    push(0, 8'd15, 8'd0, 32'hFFFFFFFF);
    game = 1'b1; ack = 1'b1; cyc(); game = 1'b0; ack = 1'b0;
    chk("t4_restart_av", {31'd0, av}, 32'd0);
    chk("t4_restart_busy", {31'd0, bz}, 32'd1);
    cyc();
    sv = 1'b1; code = 8'h5A; cyc(); sv = 1'b0;
    chk("run_sym", segs, 32'hFFFFFF5A);
    ss = 1'b1; cyc(); ss = 1'b0;
    chk("special_no_valid", {24'd0, ns}, 32'd0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("run_tl14", {24'd0, tl}, 32'd14);

    // T5b: reset mid-round, no stopGen expected
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("t5_rst_busy", {31'd0, bz}, 32'd0);
    chk("t5_rst_tl", {24'd0, tl}, 32'd0);
    chk("t5_rst_segs", segs, 32'hFFFFFFFF);
    chk("t5_rst_pulses", {30'd0, st, sp}, 32'd0);
    sv = 1'b1; code = 8'h42; cyc(); sv = 1'b0;
    chk("idle_sym_ignored", segs, 32'hFFFFFFFF);

`ifdef GP_PAUSE_EN
    // T6: pause freezes ticks and window
    start_round(8'd5, 8'd5);
    tick = 1'b1; cyc(); tick = 1'b0;
    sv = 1'b1; code = 8'h33; cyc(); sv = 1'b0;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    sv = 1'b1; code = 8'h44; cyc(2); sv = 1'b0;
    chk("t6_tl_frozen", {24'd0, tl}, 32'd4);
    chk("t6_segs_frozen", segs, 32'hFFFFFF33);
    push(1, 8'd4, 8'd0, 32'hFFFFFF33);
    abrt = 1'b1; cyc(); abrt = 1'b0; pause = 1'b0; cyc();
    chk("t6_abort_in_pause", {31'd0, bz}, 32'd0);
`endif

    cyc(4);
    chk("events_all_seen", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
